// File: rtl/mem_lut_pkg.sv
// Shared defaults, FSM state type and reset contents for the reverse address LUT.
// The table reset image is the power-on address map also used by the forward LUT.
package mem_lut_pkg;

   localparam int unsigned DEF_DEPTH = 32;
   localparam int unsigned DEF_AW    = 5;
   localparam int unsigned DEF_DW    = 8;

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      RESP
   } state_t;

   function automatic logic [DEF_DW-1:0] default_entry(input int unsigned idx);
      if (idx <= 16)
         return DEF_DW'(60 + idx);
      else if (idx == 31)
         return DEF_DW'(32);
      else
         return '0;
   endfunction

endpackage

// File: rtl/mem_lut_table.sv
// Writable lookup table storage: synchronous write port, combinational read port,
// asynchronous reset reloading the default address map.
module mem_lut_table
   import mem_lut_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = DEF_AW,
   parameter int unsigned DW    = DEF_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= DW'(default_entry(i));
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read returns the pre-edge contents, so a same-cycle write is not seen.
   always_comb rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_lut_rlookup.sv
// Reverse lookup: sequentially searches the table for a key and reports the
// lowest matching index (or a miss) through a valid/ready response.
module mem_lut_rlookup
   import mem_lut_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = DEF_AW,
   parameter int unsigned DW    = DEF_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [DW-1:0] req_value,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_hit,
   output logic [AW-1:0] rsp_index
);

   state_t        state;
   logic [DW-1:0] key;
   logic [AW-1:0] idx;
   logic [DW-1:0] entry;

   mem_lut_table #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_table (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (idx),
      .rd_data (entry)
   );

   always_comb req_ready = (state == IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         key       <= '0;
         idx       <= '0;
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rsp_index <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  key   <= req_value;
                  idx   <= '0;
                  state <= SEARCH;
               end
            end
            SEARCH: begin
               // Ascending scan: the first match is the lowest index.
               if (entry == key) begin
                  rsp_hit   <= 1'b1;
                  rsp_index <= idx;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (idx == AW'(DEPTH - 1)) begin
                  rsp_hit   <= 1'b0;
                  rsp_index <= '0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lut_rlookup.sv
// Directed bench for mem_lut_rlookup: hits, misses, latency, run-time writes,
// back-pressure and mid-search reset, all against hand-computed values.
module tb_mem_lut_rlookup;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_value;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_hit;
   logic [4:0] rsp_index;

   int errors = 0;
   int checks = 0;

   mem_lut_rlookup #(
      .DEPTH (32),
      .AW    (5),
      .DW    (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_value (req_value),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_hit   (rsp_hit),
      .rsp_index (rsp_index)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // wr_at > 0 lands one write on edge E(wr_at) after acceptance edge E0.
   task automatic do_req(input logic [7:0] value, input logic exp_hit, input int exp_idx,
                         input int exp_lat, input int wr_at, input logic [4:0] wa,
                         input logic [7:0] wd, input int hold);
      int cnt;
      logic got;
      chk($sformatf("ready_before_%0d", value), req_ready, 1);
      req_valid = 1'b1; req_value = value; rsp_ready = (hold == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk($sformatf("busy_after_accept_%0d", value), req_ready, 0);
      cnt = 0; got = 1'b0;
      while (!got && cnt < 40) begin
         if (cnt + 1 == wr_at) begin
            wr_en = 1'b1; wr_addr = wa; wr_data = wd;
         end
         @(posedge clk); #1;
         wr_en = 1'b0;
         cnt++;
         got = rsp_valid;
      end
      chk($sformatf("rsp_seen_%0d", value), got, 1);
      chk($sformatf("latency_%0d", value), cnt, exp_lat);
      chk($sformatf("hit_%0d", value), rsp_hit, exp_hit);
      chk($sformatf("index_%0d", value), rsp_index, exp_idx);
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1; req_value = 8'd60;
         @(posedge clk); #1;
         chk("hold_valid", rsp_valid, 1);
         chk("hold_hit", rsp_hit, exp_hit);
         chk("hold_index", rsp_index, exp_idx);
         chk("hold_req_ready", req_ready, 0);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("valid_cleared_%0d", value), rsp_valid, 0);
      chk($sformatf("ready_returned_%0d", value), req_ready, 1);
      chk($sformatf("hit_held_%0d", value), rsp_hit, exp_hit);
      chk($sformatf("index_held_%0d", value), rsp_index, exp_idx);
   endtask

   initial begin
      int seen;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      req_valid = 1'b0; req_value = '0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_req_ready", req_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_hit", rsp_hit, 0);
      chk("reset_rsp_index", rsp_index, 0);

      // Default map: 0..16 -> 60..76, 31 -> 32, others 0.
      do_req(8'd60, 1'b1, 0, 1, 0, 5'd0, 8'd0, 0);
      do_req(8'd76, 1'b1, 16, 17, 0, 5'd0, 8'd0, 0);
      do_req(8'd32, 1'b1, 31, 32, 0, 5'd0, 8'd0, 0);
      do_req(8'd99, 1'b0, 0, 32, 0, 5'd0, 8'd0, 0);

      // Entry 5 duplicates entry 10; lowest index wins, and 65 disappears.
      wr(5'd5, 8'd70);
      do_req(8'd70, 1'b1, 5, 6, 0, 5'd0, 8'd0, 0);
      do_req(8'd65, 1'b0, 0, 32, 0, 5'd0, 8'd0, 0);

      // Write ahead of the scan is seen; write on the compare edge is not.
      do_req(8'd200, 1'b1, 20, 21, 6, 5'd20, 8'd200, 0);
      wr(5'd20, 8'd0);
      do_req(8'd200, 1'b0, 0, 32, 21, 5'd20, 8'd200, 0);
      wr(5'd20, 8'd0);

      // Back-pressure with a stray request during RESP.
      do_req(8'd61, 1'b1, 1, 2, 0, 5'd0, 8'd0, 5);

      // Abort a search for 67 at idx 7.
      chk("abort_ready_before", req_ready, 1);
      req_valid = 1'b1; req_value = 8'd67;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("abort_no_rsp_yet", rsp_valid, 0);
      chk("abort_still_searching", req_ready, 0);
      reset = 1'b1;
      #1;
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_rsp_hit", rsp_hit, 0);
      chk("abort_rsp_index", rsp_index, 0);
      chk("abort_req_ready", req_ready, 1);
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      chk("abort_no_response", seen, 0);

      // Table defaults restored: 65 back at entry 5.
      do_req(8'd65, 1'b1, 5, 6, 0, 5'd0, 8'd0, 0);
      do_req(8'd67, 1'b1, 7, 8, 0, 5'd0, 8'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
